// File: rtl/inst_fetch_pkg.sv
// Shared widths and the fetch queue entry type for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int INST_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two synchronous FIFO of {pc, inst} entries with a synchronous flush.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  fetch_entry_t  store [DEPTH];

  assign full  = (count == (PW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = store[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= entry;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, combinational memory read, queue to decode, redirect flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              inst_read,
  output logic [ADDR_W-1:0] inst_address,
  input  logic [INST_W-1:0] inst_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc
);

  // Handshake: an entry transfers on a rising edge where if_valid && if_ready;
  // if_valid never depends on if_ready, and the head holds until accepted.

  logic [ADDR_W-1:0] pc;
  logic              run_q;
  logic              full;
  logic              empty;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      entry;

  assign inst_read    = run_q && !redirect_valid && !full;
  assign inst_address = pc;
  assign if_valid     = !empty && !redirect_valid;
  assign pop          = if_valid && if_ready;
  assign if_inst      = head.inst;
  assign if_pc        = head.pc;
  assign entry        = '{pc: pc, inst: inst_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (inst_read) pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inst_read),
    .pop   (pop),
    .flush (redirect_valid),
    .entry (entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the initiator for the instruction memory read port. Holds the program counter and issues word reads to instruction memory. Buffers returned instructions with their PCs in a small queue and hands them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and flushes in-flight work.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; bits [1:0] must be 0.
- `QUEUE_DEPTH`, default 2: fetch queue entries; power of two, minimum 2.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `inst_read` out, 1: read strobe to instruction memory.
- `inst_address` out, 32: byte address of the fetched word; always word-aligned.
- `inst_data` in, 32: instruction word from memory, valid in the same cycle as `inst_read` (combinational memory).
- `redirect_valid` in, 1: execute requests a PC change.
- `redirect_pc` in, 32: new PC target; bits [1:0] are ignored and treated as 0.
- `if_valid` out, 1: the queue head holds a valid instruction.
- `if_ready` in, 1: decode accepts the head.
- `if_inst` out, 32: instruction at the queue head.
- `if_pc` out, 32: PC of `if_inst`.

## Operation
**Registers**
- `pc`.
- `run_q`: cleared by reset, set on the first clock edge after `rst_n` rises.
- Queue storage `{pc, inst}` with read pointer, write pointer and `count`.

**Fetch (push)**
- `inst_read = run_q && !redirect_valid && (count < QUEUE_DEPTH)`.
- `inst_address = pc` at all times.
- On an edge where `inst_read` is 1:
  - push `{pc, inst_data}`;
  - `pc <= pc + 4`.
- The PC wraps modulo 2^32: `32'hFFFF_FFFC` is followed by 0.

**Deliver (pop)**
- `if_valid = (count != 0) && !redirect_valid`.
- `if_inst` and `if_pc` show the head entry.
- A pop occurs on an edge where `if_valid && if_ready`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full queue: no push that cycle, even if a pop occurs. The push resumes the next cycle.
- Empty queue: `if_valid` = 0. `if_inst` and `if_pc` hold stale data and are don't-care.

**Redirect (highest priority)**
- On an edge where `redirect_valid` is 1:
  - `count <= 0` and both pointers reset to 0;
  - `pc <= {redirect_pc[31:2], 2'b00}`;
  - no push and no pop.
- Back-to-back redirects: the last one wins. No fetch happens between them.

**Reset**
- Asynchronous: `pc <= RESET_PC`, `count <= 0`, pointers <= 0, `run_q <= 0`.
- Reset mid-operation discards all queued entries immediately.
- Output values while `rst_n` is low: `inst_read` = 0, `if_valid` = 0, `inst_address` = `RESET_PC`.

## Timing
- Fetch-to-deliver latency is 1 cycle: a word read in cycle N is presented with `if_valid` = 1 in cycle N+1.
- Sustained throughput is 1 instruction per cycle when `if_ready` is held at 1 (requires `QUEUE_DEPTH` ≥ 2).
- Redirect asserted in cycle N:
  - cycle N+1 reads `redirect_pc`;
  - the target instruction appears on `if_*` in cycle N+2.
- After reset is released at edge R, the first `inst_read` occurs in the cycle after edge R+1.
- `inst_read` and `if_valid` depend combinationally on `redirect_valid`. There is no combinational path from `if_ready` to `inst_read`.
- `if_inst` and `if_pc` must remain stable while `if_valid && !if_ready`, unless a redirect occurs.

## Structure
- Shared package `inst_fetch_pkg` contains:
  - `INST_W` = 32, `ADDR_W` = 32, `PC_STEP` = 4;
  - typedef `fetch_entry_t` struct `{logic [31:0] pc; logic [31:0] inst;}`.
- Sub-module `fetch_queue`:
  - parameterised-depth synchronous FIFO of `fetch_entry_t`;
  - ports: push, pop, flush, full, empty, head;
  - asynchronous active-low reset.
- `inst_fetch` itself holds the PC, `run_q`, and the push/pop/redirect arbitration.

## Test plan
- Reset with `RESET_PC`=`32'h100`, memory word i = `32'hA000_0000+i`, `if_ready`=1 → `if_pc` sequence 0x100, 0x104, 0x108…; `if_inst` = `A000_0040`, `A000_0041`…; first `if_valid` 2 cycles after reset release.
- Hold `if_ready`=0 for 5 cycles → queue fills to 2 (pc 0x100, 0x104); `inst_read` drops; `pc` = 0x108. On release → 0x100, 0x104, 0x108 delivered back to back with no gaps or duplicates.
- Queue full; pulse `redirect_valid` with `redirect_pc`=`32'h203` → `if_valid` = 0 during the redirect cycle, queue flushed, next fetch address 0x200, then `if_pc` = 0x200.
- Redirect on two consecutive cycles (0x40 then 0x80) → no fetch from 0x40; first delivered `if_pc` = 0x80.
- Redirect to `32'hFFFF_FFF8` → delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst_n`=0 asynchronously mid-stream with 2 entries queued → `if_valid` and `inst_read` go to 0 immediately; after release, fetch restarts at `RESET_PC`.
